// File: rtl/gen_tile_coord_pkg.sv
// rtl/gen_tile_coord_pkg.sv - shared tile-count and step helpers for gen_tile_coord
package gen_tile_coord_pkg;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Distance between adjacent spatial tile origins; tiles overlap by the kernel halo.
    function automatic int tile_step(input int tile, input int k, input int s);
        return tile + s - k;
    endfunction

    function automatic int kernel_positions(input int dim, input int k, input int s);
        return (dim + s - k) / s;
    endfunction

    function automatic int spatial_tiles(input int dim, input int tile, input int k, input int s);
        return ceil_div(kernel_positions(dim, k, s), tile_step(tile, k, s) / s);
    endfunction

    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int DEF_N_TILES   = ceil_div(128, 16);
    localparam int DEF_M_TILES   = ceil_div(256, 16);
    localparam int DEF_ROW_TILES = spatial_tiles(128, 64, 3, 1);
    localparam int DEF_COL_TILES = spatial_tiles(128, 16, 3, 1);
    localparam int DEF_ROW_STEP  = tile_step(64, 3, 1);
    localparam int DEF_COL_STEP  = tile_step(16, 3, 1);

endpackage

// File: rtl/gen_tile_coord_wrap_counter.sv
// rtl/gen_tile_coord_wrap_counter.sv - modulo-(MAX+1) index counter with carry-out
module wrap_counter
    import gen_tile_coord_pkg::*;
#(
    parameter int CW  = 4,
    parameter int MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_max;

    assign at_max = (cnt_q == CW'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (ena) begin
            cnt_d = at_max ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = ena & at_max;

endmodule

// File: rtl/gen_tile_coord.sv
// rtl/gen_tile_coord.sv - tile base coordinate generator, loop order n/row/col/m (outer to inner)
// Optional simulation checks enabled by GEN_TILE_COORD_CHECK_EN.
module gen_tile_coord
    import gen_tile_coord_pkg::*;
#(
    parameter int AW = 32,
    parameter int N  = 128,
    parameter int M  = 256,
    parameter int R  = 128,
    parameter int C  = 128,
    parameter int Tn = 16,
    parameter int Tm = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int K  = 3,
    parameter int S  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          conv_tile_done,
    output logic [AW-1:0] tile_base_n,
    output logic [AW-1:0] tile_base_m,
    output logic [AW-1:0] tile_base_row,
    output logic [AW-1:0] tile_base_col,
    output logic          last_tile
);

    localparam int ROW_STEP  = tile_step(Tr, K, S);
    localparam int COL_STEP  = tile_step(Tc, K, S);
    localparam int N_TILES   = ceil_div(N, Tn);
    localparam int M_TILES   = ceil_div(M, Tm);
    localparam int ROW_TILES = spatial_tiles(R, Tr, K, S);
    localparam int COL_TILES = spatial_tiles(C, Tc, K, S);
    localparam int N_CW      = cnt_width(N_TILES);
    localparam int M_CW      = cnt_width(M_TILES);
    localparam int ROW_CW    = cnt_width(ROW_TILES);
    localparam int COL_CW    = cnt_width(COL_TILES);

    logic [N_CW-1:0]   n_idx;
    logic [M_CW-1:0]   m_idx;
    logic [ROW_CW-1:0] row_idx;
    logic [COL_CW-1:0] col_idx;
    logic              m_wrap, col_wrap, row_wrap, n_wrap;

    wrap_counter #(.CW(M_CW), .MAX(M_TILES - 1)) u_m_cnt (
        .clk (clk), .rst (rst), .ena (conv_tile_done), .cnt (m_idx), .wrap (m_wrap)
    );

    wrap_counter #(.CW(COL_CW), .MAX(COL_TILES - 1)) u_col_cnt (
        .clk (clk), .rst (rst), .ena (m_wrap), .cnt (col_idx), .wrap (col_wrap)
    );

    wrap_counter #(.CW(ROW_CW), .MAX(ROW_TILES - 1)) u_row_cnt (
        .clk (clk), .rst (rst), .ena (col_wrap), .cnt (row_idx), .wrap (row_wrap)
    );

    wrap_counter #(.CW(N_CW), .MAX(N_TILES - 1)) u_n_cnt (
        .clk (clk), .rst (rst), .ena (row_wrap), .cnt (n_idx), .wrap (n_wrap)
    );

    // Bases track index*step by accumulation, so no multipliers are needed.
    logic [AW-1:0] base_n_q, base_m_q, base_row_q, base_col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_n_q   <= '0;
            base_m_q   <= '0;
            base_row_q <= '0;
            base_col_q <= '0;
        end else begin
            if (conv_tile_done) base_m_q   <= m_wrap   ? '0 : base_m_q   + AW'(Tm);
            if (m_wrap)         base_col_q <= col_wrap ? '0 : base_col_q + AW'(COL_STEP);
            if (col_wrap)       base_row_q <= row_wrap ? '0 : base_row_q + AW'(ROW_STEP);
            if (row_wrap)       base_n_q   <= n_wrap   ? '0 : base_n_q   + AW'(Tn);
        end
    end

    assign tile_base_n   = base_n_q;
    assign tile_base_m   = base_m_q;
    assign tile_base_row = base_row_q;
    assign tile_base_col = base_col_q;

    assign last_tile = (n_idx   == N_CW'(N_TILES - 1))
                     & (m_idx   == M_CW'(M_TILES - 1))
                     & (row_idx == ROW_CW'(ROW_TILES - 1))
                     & (col_idx == COL_CW'(COL_TILES - 1));

`ifdef GEN_TILE_COORD_CHECK_EN
    if (Tr <= K - S) begin : g_bad_tr
        $error("gen_tile_coord: Tr must exceed K-S");
    end
    if (Tc <= K - S) begin : g_bad_tc
        $error("gen_tile_coord: Tc must exceed K-S");
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (int'(n_idx) <= N_TILES - 1)     else $error("gen_tile_coord: n index out of range");
            assert (int'(m_idx) <= M_TILES - 1)     else $error("gen_tile_coord: m index out of range");
            assert (int'(row_idx) <= ROW_TILES - 1) else $error("gen_tile_coord: row index out of range");
            assert (int'(col_idx) <= COL_TILES - 1) else $error("gen_tile_coord: col index out of range");
        end
    end
`endif

endmodule

// File: tb/tb_gen_tile_coord.sv
// tb/tb_gen_tile_coord.sv - randomized checks of gen_tile_coord against a linear tile-number model
module tb_gen_tile_coord;

    localparam int AW = 32;
    localparam int N = 128, M = 256, R = 128, C = 128;
    localparam int TN = 16, TM = 16, TR = 64, TC = 16, K = 3, S = 1;
    localparam int ROW_STEP = TR + S - K;
    localparam int COL_STEP = TC + S - K;
    localparam int N_T   = (N + TN - 1) / TN;
    localparam int M_T   = (M + TM - 1) / TM;
    localparam int ROW_KN = (R + S - K) / S;
    localparam int COL_KN = (C + S - K) / S;
    localparam int R_T   = (ROW_KN + (ROW_STEP / S) - 1) / (ROW_STEP / S);
    localparam int C_T   = (COL_KN + (COL_STEP / S) - 1) / (COL_STEP / S);
    localparam int TOTAL = N_T * M_T * R_T * C_T;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          conv_tile_done = 1'b0;
    logic [AW-1:0] tile_base_n, tile_base_m, tile_base_row, tile_base_col;
    logic          last_tile;

    int checks = 0;
    int failures = 0;
    int tile_no = 0;

    gen_tile_coord #(
        .AW(AW), .N(N), .M(M), .R(R), .C(C),
        .Tn(TN), .Tm(TM), .Tr(TR), .Tc(TC), .K(K), .S(S)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .conv_tile_done (conv_tile_done),
        .tile_base_n    (tile_base_n),
        .tile_base_m    (tile_base_m),
        .tile_base_row  (tile_base_row),
        .tile_base_col  (tile_base_col),
        .last_tile      (last_tile)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".n"},    tile_base_n,   '0);
        check({tag, ".m"},    tile_base_m,   '0);
        check({tag, ".row"},  tile_base_row, '0);
        check({tag, ".col"},  tile_base_col, '0);
        check({tag, ".last"}, AW'(last_tile), '0);
    endtask

    // Tile number t maps to indices with m fastest, then col, row, n.
    task automatic check_model(input string tag);
        int m_i, c_i, r_i, n_i;
        m_i = tile_no % M_T;
        c_i = (tile_no / M_T) % C_T;
        r_i = (tile_no / (M_T * C_T)) % R_T;
        n_i = tile_no / (M_T * C_T * R_T);
        check({tag, ".n"},    tile_base_n,    AW'(n_i * TN));
        check({tag, ".m"},    tile_base_m,    AW'(m_i * TM));
        check({tag, ".row"},  tile_base_row,  AW'(r_i * ROW_STEP));
        check({tag, ".col"},  tile_base_col,  AW'(c_i * COL_STEP));
        check({tag, ".last"}, AW'(last_tile), AW'(tile_no == TOTAL - 1));
    endtask

    // Issue k advances as random-length held bursts separated by random idle gaps.
    task automatic advance(input int k);
        int left, len, gap;
        left = k;
        while (left > 0) begin
            len = $urandom_range(1, (left < 5) ? left : 5);
            conv_tile_done = 1'b1;
            repeat (len) @(negedge clk);
            conv_tile_done = 1'b0;
            left -= len;
            tile_no = (tile_no + len) % TOTAL;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic advance_to(input int target, input string tag);
        advance(target - tile_no);
        check_model(tag);
    endtask

    initial begin
        conv_tile_done = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst = 1'b0;
        conv_tile_done = 1'b0;
        @(negedge clk);
        check_zero("after_reset");
        repeat (4) @(negedge clk);
        check_zero("idle_hold");

        advance_to(1, "p1");
        advance_to(16, "p16");
        check("p16_col_direct", tile_base_col, AW'(14));
        advance_to(144, "p144");
        check("p144_row_direct", tile_base_row, AW'(62));
        advance_to(432, "p432");
        check("p432_n_direct", tile_base_n, AW'(16));
        for (int i = 0; i < 6; i++) begin
            advance_to(tile_no + $urandom_range(1, 400), "rand");
        end
        advance_to(TOTAL - 1, "p3455");
        check("p3455_last_direct", AW'(last_tile), AW'(1));
        advance_to(TOTAL, "wrap_tmp");
        advance(0);

        // Fresh layer after wrap: three-cycle held pulse lands on m=48.
        conv_tile_done = 1'b1;
        repeat (3) @(negedge clk);
        conv_tile_done = 1'b0;
        tile_no = 3;
        check("held3_m", tile_base_m, AW'(48));
        check_model("held3");

        advance_to(500, "p500");
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        tile_no = 0;
        check_zero("post_reset");
        advance_to($urandom_range(20, 300), "restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
